// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_dif.sv
// One-bit full subtractor: d = s - i - bin, bout set when the bit underflows.
module full_dif (
    input  logic s,
    input  logic i,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = s ^ i ^ bin;
    assign bout = (~s & i) | (~(s ^ i) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock; start/busy/done handshake.
// WIDTH+1 cycles start-to-done; start is ignored while busy.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_load;
    logic             w_last;
    logic             w_d;
    logic             w_bout;

    full_dif u_cell (
        .s    (r_sa[0]),
        .i    (r_sb[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The minuend register doubles as the result shift register: each freed MSB takes a difference bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_sa   <= a;
                r_sb   <= b;
                r_br   <= 1'b0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                r_sa <= {w_d, r_sa[WIDTH-1:1]};
                r_sb <= {1'b0, r_sb[WIDTH-1:1]};
                r_br <= w_bout;
                if (w_last) begin
                    r_diff   <= {w_d, r_sa[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed + random bench for serial_sub_ctrl with a result scoreboard.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] sb_q[$];
    logic           prev_done = 1'b0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every done pops one expected {borrow, diff}; done must be a single-cycle pulse.
    always @(negedge clk) begin
        logic [WIDTH:0] exp_v;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                checks++;
                assert (prev_done === 1'b0) else begin
                    errors++;
                    $error("FAIL done_pulse: done high %0d cycles in a row, required 1", 2);
                end
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_done: done=1 with %0d pending, required >0", sb_q.size());
                end
                if (sb_q.size() > 0) begin
                    exp_v = sb_q.pop_front();
                    checks++;
                    assert ({borrow_out, diff} === exp_v) else begin
                        errors++;
                        $error("FAIL result: got borrow=%0b diff=%h, required borrow=%0b diff=%h",
                               borrow_out, diff, exp_v[WIDTH], exp_v[WIDTH-1:0]);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h, required %h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        sb_q.push_back({1'b0, av} - {1'b0, bv});
        step();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < WIDTH + 6) begin
            step();
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        chk("rst_diff",   {24'd0, diff},       32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // 5A - 3C, then a back-to-back op launched on the DONE cycle
        start_op(8'h5A, 8'h3C);
        wait_done(n);
        chk("latency_5a", n, WIDTH);
        chk("busy_on_done", {31'd0, busy}, 32'd0);
        start_op(8'h10, 8'h20);
        step(); step(); step();
        chk("diff_hold", {24'd0, diff}, 32'h1E);
        chk("borrow_hold", {31'd0, borrow_out}, 32'd0);
        wait_done(n);
        chk("latency_b2b", n, WIDTH - 3);
        step(); step();

        start_op(8'h00, 8'h01);
        wait_done(n);
        step();
        start_op(8'hFF, 8'hFF);
        wait_done(n);
        step();

        // start pulsed mid-operation must be ignored
        start_op(8'h77, 8'h22);
        step();
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h00;
        step();
        start = 1'b0;
        wait_done(n);
        chk("latency_ignored", n, WIDTH - 2);
        seen = 0;
        repeat (12) begin
            step();
            if (done) seen++;
        end
        chk("no_extra_done", seen, 0);
        chk("diff_after_ignore", {24'd0, diff}, 32'h55);

        // asynchronous reset mid-operation
        start_op(8'h80, 8'h01);
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, busy},       32'd0);
        chk("arst_done",   {31'd0, done},       32'd0);
        chk("arst_diff",   {24'd0, diff},       32'd0);
        chk("arst_borrow", {31'd0, borrow_out}, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            step();
            if (done) seen++;
        end
        chk("no_done_after_rst", seen, 0);

        for (int k = 0; k < 1000; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            start_op(ra, rb);
            wait_done(n);
            chk("latency_rand", n, WIDTH);
            step();
        end
        step(); step();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
